// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite controllers.
// anim_state_t : animation sequencer states
// SCREEN_W/H   : visible screen size, shared by every sprite controller
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } anim_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator.
// Turns the current draw pixel into a ROM address inside the active frame,
// optionally mirrored horizontally, and flags whether the pixel lies inside
// the sprite box. Outputs are registered: one cycle of latency.
// Ports:
//   vga_clk, reset        : pixel clock, synchronous active-high reset
//   flip                  : mirror horizontally
//   sprite_x, sprite_y    : sprite top-left corner on screen
//   draw_x, draw_y        : current pixel from the VGA controller
//   frame_idx             : frame currently displayed
//   rom_address           : ROM address for the pixel (0 when outside)
//   sprite_hit            : pixel inside the sprite box
module sprite_addr_gen #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 96,
  parameter int ADDR_W  = 16
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              flip,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [2:0]        frame_idx,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_hit
);

  localparam int FRAME_SIZE = FRAME_W * FRAME_H;

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [9:0]         lx;
  logic               in_box;
  logic [ADDR_W-1:0]  addr_next;

  // Offsets are 11-bit signed so pixels left of / above the sprite go negative.
  assign dx = $signed({1'b0, draw_x}) - $signed({1'b0, sprite_x});
  assign dy = $signed({1'b0, draw_y}) - $signed({1'b0, sprite_y});

  always_comb begin
    in_box    = 1'b0;
    lx        = '0;
    addr_next = '0;
    in_box = !dx[10] && (dx[9:0] < 10'(FRAME_W)) &&
             !dy[10] && (dy[9:0] < 10'(FRAME_H));
    lx = flip ? (10'(FRAME_W - 1) - dx[9:0]) : dx[9:0];
    if (in_box) begin
      addr_next = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SIZE)
                + ADDR_W'(dy[9:0]) * ADDR_W'(FRAME_W)
                + ADDR_W'(lx);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      sprite_hit  <= 1'b0;
    end else begin
      rom_address <= addr_next;
      sprite_hit  <= in_box;
    end
  end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer and address generator for one sprite ROM/palette pair.
// Steps the displayed frame on vertical-blank ticks and maps the current draw
// pixel into the active frame's ROM address. The ROM samples rom_address on
// the falling edge, so colour is available on the following rising edge.
// Ports:
//   vga_clk, reset        : pixel clock, synchronous active-high reset
//   vsync                 : VGA vsync level (active-low); tick = falling edge
//   start, loop           : start pulse, loop mode sampled with start
//   stop                  : abort to IDLE showing frame 0 (beats start)
//   flip                  : mirror horizontally
//   sprite_x/y, draw_x/y  : sprite position and current pixel
//   rom_address, sprite_hit : registered pixel address and in-box flag
//   frame_idx             : frame currently displayed
//   busy                  : animating (PLAY or HOLD)
//   done                  : 1-cycle pulse when a one-shot finishes
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int FRAME_W     = 64,
  parameter int FRAME_H     = 96,
  parameter int NUM_FRAMES  = 8,
  parameter int FRAME_TICKS = 6,
  parameter int ADDR_W      = 16
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              start,
  input  logic              loop,
  input  logic              stop,
  input  logic              flip,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_hit,
  output logic [2:0]        frame_idx,
  output logic              busy,
  output logic              done
);

  // A 1-bit counter still works when FRAME_TICKS is 1 (it just stays 0).
  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  anim_state_t      state;
  logic [CNT_W-1:0] tick_cnt;
  logic             loop_latch;
  logic             vsync_prev;
  logic             tick;
  logic             last_tick;
  logic             last_frame;

  // History starts high so a vsync held low out of reset is not a tick.
  always_ff @(posedge vga_clk) begin
    if (reset) vsync_prev <= 1'b1;
    else       vsync_prev <= vsync;
  end

  assign tick       = vsync_prev & ~vsync;
  assign last_tick  = (tick_cnt == CNT_W'(FRAME_TICKS - 1));
  assign last_frame = (frame_idx == 3'(NUM_FRAMES - 1));

  // Sequencer: stop beats start, start restarts from any state.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      loop_latch <= 1'b0;
      frame_idx  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        tick_cnt  <= '0;
        frame_idx <= '0;
        busy      <= 1'b0;
      end else if (start) begin
        state      <= PLAY;
        tick_cnt   <= '0;
        loop_latch <= loop;
        frame_idx  <= '0;
        busy       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            frame_idx <= '0;
            busy      <= 1'b0;
          end
          PLAY: begin
            if (tick) begin
              if (last_tick) begin
                tick_cnt <= '0;
                if (!last_frame) begin
                  frame_idx <= frame_idx + 3'd1;
                end else if (loop_latch) begin
                  frame_idx <= '0;
                end else begin
                  state <= HOLD;
                  done  <= 1'b1;
                end
              end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
              end
            end
          end
          HOLD: begin
            if (tick) begin
              state     <= IDLE;
              frame_idx <= '0;
              busy      <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            frame_idx <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  sprite_addr_gen #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .flip        (flip),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .frame_idx   (frame_idx),
    .rom_address (rom_address),
    .sprite_hit  (sprite_hit)
  );

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed testbench for sprite_anim_ctrl with hand-computed expectations.
module tb_sprite_anim_ctrl;

  logic        vga_clk;
  logic        reset;
  logic        vsync;
  logic        start;
  logic        loop;
  logic        stop;
  logic        flip;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [15:0] rom_address;
  logic        sprite_hit;
  logic [2:0]  frame_idx;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  int done_cnt;

  sprite_anim_ctrl dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .vsync       (vsync),
    .start       (start),
    .loop        (loop),
    .stop        (stop),
    .flip        (flip),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .rom_address (rom_address),
    .sprite_hit  (sprite_hit),
    .frame_idx   (frame_idx),
    .busy        (busy),
    .done        (done)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // One vsync falling edge; done is sampled after both edges so no pulse is missed.
  task automatic vsync_tick();
    vsync = 1'b0;
    @(posedge vga_clk); #1;
    if (done === 1'b1) done_cnt++;
    vsync = 1'b1;
    @(posedge vga_clk); #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) vsync_tick();
  endtask

  task automatic pulse_start(input logic lp);
    start = 1'b1;
    loop  = lp;
    @(posedge vga_clk); #1;
    start = 1'b0;
    loop  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1;
    reset = 1'b0;
    checks++;
    if (frame_idx !== 3'd0 || busy !== 1'b0 || done !== 1'b0 ||
        rom_address !== 16'd0 || sprite_hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: frame=%0d busy=%0b done=%0b addr=%0d hit=%0b, required all 0",
               frame_idx, busy, done, rom_address, sprite_hit);
    end
    // Put a pixel inside the box so reset has something to clear.
    sprite_x = 10'd100; sprite_y = 10'd50; draw_x = 10'd103; draw_y = 10'd60;
    pulse_start(1'b1);
    tick_n(18);
    checks++;
    if (frame_idx !== 3'd3 || sprite_hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_frame3: frame=%0d hit=%0b, required 3/1", frame_idx, sprite_hit);
    end
    reset = 1'b1;
    @(posedge vga_clk); #1;
    reset = 1'b0;
    checks++;
    if (frame_idx !== 3'd0 || busy !== 1'b0 || rom_address !== 16'd0 || sprite_hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_play: frame=%0d busy=%0b addr=%0d hit=%0b, required 0/0/0/0",
               frame_idx, busy, rom_address, sprite_hit);
    end
  endtask

  task automatic test_loop();
    done_cnt = 0;
    pulse_start(1'b1);
    checks++;
    if (frame_idx !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL loop_start: frame=%0d busy=%0b, required 0/1", frame_idx, busy);
    end
    for (int k = 1; k <= 48; k++) begin
      vsync_tick();
      checks++;
      if (frame_idx !== 3'((k / 6) % 8) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL loop_tick%0d: frame=%0d busy=%0b, required %0d/1",
                 k, frame_idx, busy, (k / 6) % 8);
      end
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL loop_no_done: done pulses=%0d, required 0", done_cnt);
    end
  endtask

  task automatic test_one_shot();
    done_cnt = 0;
    pulse_start(1'b0);
    tick_n(47);
    checks++;
    if (frame_idx !== 3'd7 || busy !== 1'b1 || done_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL oneshot_47: frame=%0d busy=%0b done pulses=%0d, required 7/1/0",
               frame_idx, busy, done_cnt);
    end
    tick_n(1);
    checks++;
    if (done_cnt !== 1 || frame_idx !== 3'd7 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oneshot_hold: done pulses=%0d frame=%0d busy=%0b done_now=%0b, required 1/7/1/0",
               done_cnt, frame_idx, busy, done);
    end
    tick_n(1);
    checks++;
    if (frame_idx !== 3'd0 || busy !== 1'b0 || done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL oneshot_idle: frame=%0d busy=%0b done pulses=%0d, required 0/0/1",
               frame_idx, busy, done_cnt);
    end
  endtask

  task automatic test_address();
    pulse_start(1'b1);
    tick_n(12);
    sprite_x = 10'd100; sprite_y = 10'd50;
    draw_x = 10'd103; draw_y = 10'd60; flip = 1'b0;
    @(posedge vga_clk); #1;
    checks++;
    if (frame_idx !== 3'd2 || rom_address !== 16'd12931 || sprite_hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL addr_noflip: frame=%0d addr=%0d hit=%0b, required 2/12931/1",
               frame_idx, rom_address, sprite_hit);
    end
    flip = 1'b1;
    @(posedge vga_clk); #1;
    checks++;
    if (rom_address !== 16'd12988 || sprite_hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL addr_flip: addr=%0d hit=%0b, required 12988/1", rom_address, sprite_hit);
    end
    flip = 1'b0;
    draw_x = 10'd99; draw_y = 10'd60;
    @(posedge vga_clk); #1;
    checks++;
    if (rom_address !== 16'd0 || sprite_hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addr_left_edge: addr=%0d hit=%0b, required 0/0", rom_address, sprite_hit);
    end
    draw_x = 10'd164;
    @(posedge vga_clk); #1;
    checks++;
    if (rom_address !== 16'd0 || sprite_hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addr_right_edge: addr=%0d hit=%0b, required 0/0", rom_address, sprite_hit);
    end
    // Bottom-right corner: 2*6144 + 95*64 + 63
    draw_x = 10'd163; draw_y = 10'd145;
    @(posedge vga_clk); #1;
    checks++;
    if (rom_address !== 16'd18431 || sprite_hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL addr_corner: addr=%0d hit=%0b, required 18431/1", rom_address, sprite_hit);
    end
    draw_y = 10'd146;
    @(posedge vga_clk); #1;
    checks++;
    if (rom_address !== 16'd0 || sprite_hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addr_below: addr=%0d hit=%0b, required 0/0", rom_address, sprite_hit);
    end
    // Top-left corner mirrored: 2*6144 + 0 + 63
    draw_x = 10'd100; draw_y = 10'd50; flip = 1'b1;
    @(posedge vga_clk); #1;
    checks++;
    if (rom_address !== 16'd12351 || sprite_hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL addr_topleft_flip: addr=%0d hit=%0b, required 12351/1", rom_address, sprite_hit);
    end
    flip = 1'b0;
    draw_y = 10'd49;
    @(posedge vga_clk); #1;
    checks++;
    if (rom_address !== 16'd0 || sprite_hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addr_above: addr=%0d hit=%0b, required 0/0", rom_address, sprite_hit);
    end
  endtask

  task automatic test_restart();
    pulse_start(1'b1);
    tick_n(13);
    checks++;
    if (frame_idx !== 3'd2) begin
      failures++;
      $display("[TB] FAIL restart_pre: frame=%0d, required 2", frame_idx);
    end
    pulse_start(1'b0);
    checks++;
    if (frame_idx !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL restart_in_play: frame=%0d busy=%0b, required 0/1", frame_idx, busy);
    end
    // Counter restarted too: frame 1 only after a full 6 ticks.
    tick_n(5);
    checks++;
    if (frame_idx !== 3'd0) begin
      failures++;
      $display("[TB] FAIL restart_cnt5: frame=%0d, required 0", frame_idx);
    end
    tick_n(1);
    checks++;
    if (frame_idx !== 3'd1) begin
      failures++;
      $display("[TB] FAIL restart_cnt6: frame=%0d, required 1", frame_idx);
    end
  endtask

  task automatic test_stop_start();
    done_cnt = 0;
    pulse_start(1'b0);
    tick_n(7);
    checks++;
    if (frame_idx !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stopstart_pre: frame=%0d busy=%0b, required 1/1", frame_idx, busy);
    end
    stop = 1'b1; start = 1'b1; loop = 1'b1;
    @(posedge vga_clk); #1;
    stop = 1'b0; start = 1'b0; loop = 1'b0;
    checks++;
    if (frame_idx !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_start_same: frame=%0d busy=%0b done=%0b, required 0/0/0",
               frame_idx, busy, done);
    end
    tick_n(6);
    checks++;
    if (frame_idx !== 3'd0 || busy !== 1'b0 || done_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL stop_stays_idle: frame=%0d busy=%0b done pulses=%0d, required 0/0/0",
               frame_idx, busy, done_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    done_cnt = 0;
    reset    = 1'b1;
    vsync    = 1'b1;
    start    = 1'b0;
    loop     = 1'b0;
    stop     = 1'b0;
    flip     = 1'b0;
    sprite_x = '0;
    sprite_y = '0;
    draw_x   = '0;
    draw_y   = '0;
    $display("[TB] sprite_anim_ctrl directed tests starting");
    test_reset();
    test_loop();
    stop = 1'b1; @(posedge vga_clk); #1; stop = 1'b0;
    test_one_shot();
    test_address();
    test_restart();
    test_stop_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
